// File: rtl/count_checker.sv
// Purpose : checks that a 4-bit upstream counter advances by exactly one per
//           valid sample, locks after LOCK_N in-sequence steps and keeps
//           error and wrap statistics.
// Latency : all outputs registered, visible the cycle after the sampling edge.
// Backpressure: none; samples are taken whenever en is high, state holds otherwise.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   qd        4-bit count value from the upstream counter
//   en        qd is valid this cycle
//   clr       synchronous clear of checker state and statistics (beats en)
//   locked    high while in LOCKED
//   err_pulse one-cycle pulse per sequence break detected in LOCKED
//   err       sticky error flag
//   err_cnt   saturating count of sequence breaks
//   wrap_cnt  modulo count of in-sequence 15->0 wraps seen while LOCKED
module count_checker #(
    parameter int LOCK_N = 2,
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        qd,
    input  logic              en,
    input  logic              clr,
    output logic              locked,
    output logic              err_pulse,
    output logic              err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [WRAP_W-1:0] wrap_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        prev, prev_nxt;
    logic [3:0]        run, run_nxt;
    logic              locked_nxt;
    logic              err_pulse_nxt;
    logic              err_nxt;
    logic [ERR_W-1:0]  err_cnt_nxt;
    logic [WRAP_W-1:0] wrap_cnt_nxt;

    logic [3:0] prev_inc;
    logic [3:0] run_inc;
    logic       match;

    // 4-bit add wraps naturally, so 15->0 counts as in-sequence
    assign prev_inc = prev + 4'd1;
    assign run_inc  = run + 4'd1;
    assign match    = (qd == prev_inc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            prev      <= 4'd0;
            run       <= 4'd0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
            wrap_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            prev      <= prev_nxt;
            run       <= run_nxt;
            locked    <= locked_nxt;
            err_pulse <= err_pulse_nxt;
            err       <= err_nxt;
            err_cnt   <= err_cnt_nxt;
            wrap_cnt  <= wrap_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        prev_nxt      = prev;
        run_nxt       = run;
        err_pulse_nxt = 1'b0;
        err_nxt       = err;
        err_cnt_nxt   = err_cnt;
        wrap_cnt_nxt  = wrap_cnt;

        if (clr) begin
            // coincident sample is dropped; prev is left alone because the
            // first sample out of IDLE overwrites it anyway
            state_nxt    = IDLE;
            run_nxt      = 4'd0;
            err_nxt      = 1'b0;
            err_cnt_nxt  = '0;
            wrap_cnt_nxt = '0;
        end else if (en) begin
            prev_nxt = qd;
            case (state)
                IDLE: begin
                    run_nxt   = 4'd0;
                    state_nxt = SYNC;
                end
                SYNC: begin
                    if (match) begin
                        run_nxt = run_inc;
                        if (run_inc == 4'(LOCK_N))
                            state_nxt = LOCKED;
                    end else begin
                        // breaks while acquiring are silent
                        run_nxt = 4'd0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        if (prev == 4'd15)
                            wrap_cnt_nxt = wrap_cnt + 1'b1;
                    end else begin
                        err_pulse_nxt = 1'b1;
                        err_nxt       = 1'b1;
                        if (err_cnt != {ERR_W{1'b1}})
                            err_cnt_nxt = err_cnt + 1'b1;
                        run_nxt   = 4'd0;
                        state_nxt = SYNC;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        locked_nxt = (state_nxt == LOCKED);
    end

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker: LOCK_N=2, WRAP_W=2, ERR_W=2 so that
// wrap modulo and error saturation are reached in a short run.
// Inputs change #1 after the rising edge; outputs are checked #1 after the next edge.
module tb_count_checker;

    logic       clk;
    logic       reset;
    logic [3:0] qd;
    logic       en;
    logic       clr;
    logic       locked;
    logic       err_pulse;
    logic       err;
    logic [1:0] err_cnt;
    logic [1:0] wrap_cnt;

    int checks;
    int errors;

    count_checker #(
        .LOCK_N (2),
        .WRAP_W (2),
        .ERR_W  (2)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .qd        (qd),
        .en        (en),
        .clr       (clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err       (err),
        .err_cnt   (err_cnt),
        .wrap_cnt  (wrap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // one clock with the given inputs, returns #1 after the edge
    task automatic cyc(input logic e, input logic [3:0] q, input logic c);
        en  = e;
        qd  = q;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    // packs all outputs: {locked, err_pulse, err, err_cnt[1:0], wrap_cnt[1:0]}
    function automatic int outs();
        return int'({locked, err_pulse, err, err_cnt, wrap_cnt});
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        en     = 1'b0;
        qd     = 4'd0;
        clr    = 1'b0;

        // held in reset while samples toggle: everything stays at zero
        #1;
        check("reset_initial", outs(), 0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 4'(i * 3), 1'b0);
            check("reset_hold", outs(), 0);
        end

        // release, then 3,4,5 locks on the cycle after 5
        reset = 1'b1;
        cyc(1'b1, 4'd3, 1'b0);
        check("first_sample_locked", int'(locked), 0);
        cyc(1'b1, 4'd4, 1'b0);
        check("sync_run1_locked", int'(locked), 0);
        cyc(1'b1, 4'd5, 1'b0);
        check("lock_after_5", int'(locked), 1);
        check("lock_no_err", int'(err), 0);

        // run up to 15, then wrap
        for (int q = 6; q <= 15; q++) cyc(1'b1, 4'(q), 1'b0);
        check("pre_wrap_cnt", int'(wrap_cnt), 0);
        cyc(1'b1, 4'd0, 1'b0);
        check("wrap_cnt_1", int'(wrap_cnt), 1);
        check("wrap_no_pulse", int'(err_pulse), 0);
        check("wrap_still_locked", int'(locked), 1);
        cyc(1'b1, 4'd1, 1'b0);
        check("post_wrap_cnt", int'(wrap_cnt), 1);

        // 2..7 then upstream reset to 0
        for (int q = 2; q <= 7; q++) cyc(1'b1, 4'(q), 1'b0);
        check("locked_at_7", int'(locked), 1);
        cyc(1'b1, 4'd0, 1'b0);
        check("break_pulse", int'(err_pulse), 1);
        check("break_err", int'(err), 1);
        check("break_cnt", int'(err_cnt), 1);
        check("break_unlocked", int'(locked), 0);
        cyc(1'b1, 4'd1, 1'b0);
        check("pulse_one_cycle", int'(err_pulse), 0);
        check("resync_locked", int'(locked), 0);
        cyc(1'b1, 4'd2, 1'b0);
        check("relock", int'(locked), 1);
        check("err_sticky", int'(err), 1);

        // en low: nothing moves regardless of qd (packed: 1,0,1,01,01)
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 4'($urandom_range(15)), 1'b0);
            check("en_low_hold", outs(), 7'b1010101);
        end
        cyc(1'b1, 4'd3, 1'b0);
        check("resume_locked", int'(locked), 1);
        check("resume_no_pulse", int'(err_pulse), 0);
        check("resume_cnt", int'(err_cnt), 1);

        // four more breaks (5 total) with relocks in between
        cyc(1'b1, 4'd3, 1'b0);               // qd == prev
        check("repeat_break_cnt", int'(err_cnt), 2);
        check("repeat_break_pulse", int'(err_pulse), 1);
        cyc(1'b1, 4'd4, 1'b0);
        cyc(1'b1, 4'd5, 1'b0);
        check("relock2", int'(locked), 1);
        cyc(1'b1, 4'd9, 1'b0);
        check("cnt_3", int'(err_cnt), 3);
        cyc(1'b1, 4'd10, 1'b0);
        cyc(1'b1, 4'd11, 1'b0);
        cyc(1'b1, 4'd0, 1'b0);
        check("sat_4th", int'(err_cnt), 3);
        check("sat_4th_pulse", int'(err_pulse), 1);
        cyc(1'b1, 4'd1, 1'b0);
        cyc(1'b1, 4'd2, 1'b0);
        check("relock4", int'(locked), 1);
        cyc(1'b1, 4'd7, 1'b0);
        check("sat_5th", int'(err_cnt), 3);

        // mismatch while in SYNC is silent
        cyc(1'b1, 4'd9, 1'b0);
        check("sync_mismatch_pulse", int'(err_pulse), 0);
        check("sync_mismatch_locked", int'(locked), 0);
        cyc(1'b1, 4'd10, 1'b0);
        check("sync_run1", int'(locked), 0);
        cyc(1'b1, 4'd11, 1'b0);
        check("relock5", int'(locked), 1);

        // three more wraps: 1 -> 2 -> 3 -> 0 (modulo 4)
        begin
            int nw;
            nw = 0;
            for (int i = 0; i < 48; i++) begin
                cyc(1'b1, 4'((12 + i) % 16), 1'b0);
                if (((12 + i) % 16) == 0) begin
                    nw++;
                    check("wrap_modulo", int'(wrap_cnt), (1 + nw) % 4);
                end
            end
            check("wrap_count_seen", nw, 3);
        end
        check("wrap_loop_no_err_cnt_change", int'(err_cnt), 3);

        // clr with en: statistics cleared, sample dropped, back to IDLE
        cyc(1'b1, 4'd12, 1'b1);
        check("clr_outs", outs(), 0);
        // 12 would match prev=11; from IDLE it only starts sync
        cyc(1'b1, 4'd12, 1'b0);
        check("after_clr_idle", int'(locked), 0);
        cyc(1'b1, 4'd13, 1'b0);
        check("after_clr_run1", int'(locked), 0);
        cyc(1'b1, 4'd14, 1'b0);
        check("after_clr_lock", int'(locked), 1);
        check("after_clr_err", int'(err), 0);

        // break, then asynchronous reset between edges
        cyc(1'b1, 4'd2, 1'b0);
        check("pre_reset_pulse", int'(err_pulse), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", outs(), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(1'b1, 4'd8, 1'b0);
        check("post_reset_first", int'(locked), 0);
        cyc(1'b1, 4'd9, 1'b0);
        cyc(1'b1, 4'd10, 1'b0);
        check("post_reset_lock", int'(locked), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_checker.md
COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 SHALL have parameter LOCK_N, default 2: consecutive in-sequence samples required to enter LOCKED (1..15).
REQ-002 SHALL have parameter WRAP_W, default 8: wrap_cnt width.
REQ-003 SHALL have parameter ERR_W, default 8: err_cnt width.
REQ-004 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous active-low reset.
REQ-006 SHALL have port qd  in  4  count value from upstream 4-bit counter.
REQ-007 SHALL have port en  in  1  qd valid this cycle; sampled at rising edge.
REQ-008 SHALL have port clr  in  1  synchronous clear of checker state and statistics.
REQ-009 SHALL have port locked  out  1  high while FSM is in LOCKED.
REQ-010 SHALL have port err_pulse  out  1  one-cycle pulse per detected sequence break.
REQ-011 SHALL have port err  out  1  sticky error flag.
REQ-012 SHALL have port err_cnt  out  ERR_W  number of sequence breaks, saturating.
REQ-013 SHALL have port wrap_cnt  out  WRAP_W  number of in-sequence 15->0 wraps seen while LOCKED, modulo 2^WRAP_W.

Function
REQ-014 SHALL keep internal prev[3:0] (last sampled qd) and run counter (good samples since last break).
REQ-015 SHALL define "match" as qd == (prev + 1) mod 16; 15->0 is a match; qd == prev is a mismatch.
REQ-016 SHALL implement FSM states IDLE, SYNC, LOCKED; all outputs registered, visible in the cycle after the sampling edge.
REQ-017 IDLE: on en, prev <= qd, run <= 0, go SYNC; no error possible in IDLE.
REQ-018 SYNC: on en and match, run++; when run+1 == LOCK_N go LOCKED; on en and mismatch, run <= 0, stay SYNC, no error reported.
REQ-019 LOCKED: on en and match, stay; if prev==15 and qd==0, wrap_cnt increments (wraps at 2^WRAP_W).
REQ-020 LOCKED: on en and mismatch, err_pulse <= 1 for exactly one cycle, err <= 1, err_cnt++ (holds at 2^ERR_W-1), run <= 0, go SYNC.
REQ-021 SHALL update prev <= qd on every en sample in every state.
REQ-022 SHALL hold all state when en is low; err_pulse low in any cycle not following a LOCKED mismatch.
REQ-023 clr SHALL have priority over en: next state IDLE, run, err, err_pulse, err_cnt, wrap_cnt cleared; the coincident en sample is discarded.
REQ-024 Upstream counter reset mid-sequence (qd jumps to 0 from non-15) SHALL be treated as a normal mismatch.

Reset
REQ-025 reset low SHALL immediately force state IDLE, prev=0, run=0, locked=0, err_pulse=0, err=0, err_cnt=0, wrap_cnt=0, independent of clk.
REQ-026 Release SHALL be synchronised externally; first en sample after release is handled as in IDLE.

Verification
REQ-027 reset low, en=1 toggling qd -> all outputs 0 throughout; after release first sample moves to SYNC, locked=0.
REQ-028 LOCK_N=2, en=1, qd=3,4,5 -> locked rises the cycle after qd=5 is sampled; err=0.
REQ-029 locked, qd runs 14,15,0,1 -> wrap_cnt 0->1 the cycle after qd=0 sampled; no err_pulse.
REQ-030 locked, qd 6,7,0 (upstream reset) -> err_pulse high exactly one cycle, err=1, err_cnt=1, locked=0; then 1,2 -> locked=1 again, err stays 1.
REQ-031 ERR_W=2, force 5 breaks from LOCKED -> err_cnt saturates at 3; clr asserted with en=1 -> next cycle all stats 0, state IDLE.
REQ-032 locked, en low for 10 cycles while qd changes arbitrarily -> no state or output change; resume with prev+1 -> still locked, no error.
